// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, receiver
// FSM states and the data-bit clamp helper.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    // Requests below 5 run as 5 bits; requests above max_bits run as max_bits.
    function automatic logic [3:0] clamp_dbit(input logic [3:0] req,
                                              input logic [3:0] max_bits);
        logic [3:0] r;
        r = req;
        if (req < 4'd5)
            r = 4'd5;
        else if (req > max_bits)
            r = max_bits;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; push is accepted when full only
// if a pop happens in the same cycle, and pop is ignored when empty.
module sync_fifo #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with FIFO and valid/ready output stream.
// Define UART_RX_BREAK_EN to add line-break detection and the brk pulse.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DBIT  = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic [7:0]      os_tick,
    input  logic [3:0]      dbit,
    input  logic [1:0]      pbit,
    input  logic            rx,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DBIT-1:0] m_data,
    output logic            m_perr,
    output logic            m_ferr,
    output logic            overrun,
`ifdef UART_RX_BREAK_EN
    output logic            brk,
`endif
    output logic [AW:0]     fifo_count
);

    logic            rx_meta, rx_sync;
    rx_state_t       state, state_n;
    logic [7:0]      tick_cnt, tick_cnt_n;
    logic [7:0]      os_l, os_l_n;
    logic [3:0]      bit_idx, bit_idx_n;
    logic [3:0]      dbit_l, dbit_l_n;
    logic [1:0]      pbit_l, pbit_l_n;
    logic [DBIT-1:0] data_q, data_n;
    logic            par_q, par_n;
    logic            perr_q, perr_n;
    logic            par_rx_q, par_rx_n;
    logic            push;
    logic            sample;
    logic            par_en;
    logic [7:0]      half_last, bit_last;
    logic            pop;
    logic            fifo_full, fifo_empty;
    logic [DBIT+1:0] fifo_wdata, fifo_rdata;
`ifdef UART_RX_BREAK_EN
    logic            brk_hit;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign half_last = {1'b0, os_l[7:1]} - 8'd1;
    assign bit_last  = os_l - 8'd1;
    assign sample    = s_tick && (tick_cnt == bit_last);
    assign par_en    = (pbit_l == PAR_EVEN) || (pbit_l == PAR_ODD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            os_l     <= '0;
            bit_idx  <= '0;
            dbit_l   <= '0;
            pbit_l   <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
            par_rx_q <= 1'b0;
            overrun  <= 1'b0;
`ifdef UART_RX_BREAK_EN
            brk      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            os_l     <= os_l_n;
            bit_idx  <= bit_idx_n;
            dbit_l   <= dbit_l_n;
            pbit_l   <= pbit_l_n;
            data_q   <= data_n;
            par_q    <= par_n;
            perr_q   <= perr_n;
            par_rx_q <= par_rx_n;
            overrun  <= push & fifo_full & ~pop;
`ifdef UART_RX_BREAK_EN
            brk      <= brk_hit;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        os_l_n     = os_l;
        bit_idx_n  = bit_idx;
        dbit_l_n   = dbit_l;
        pbit_l_n   = pbit_l;
        data_n     = data_q;
        par_n      = par_q;
        perr_n     = perr_q;
        par_rx_n   = par_rx_q;
        push       = 1'b0;
`ifdef UART_RX_BREAK_EN
        brk_hit    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!rx_sync) begin
                    state_n    = ST_START;
                    tick_cnt_n = '0;
                    dbit_l_n   = clamp_dbit(dbit, 4'(DBIT));
                    pbit_l_n   = pbit;
                    os_l_n     = os_tick;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (tick_cnt == half_last) begin
                        if (rx_sync) begin
                            state_n = ST_IDLE;
                        end else begin
                            state_n    = ST_DATA;
                            tick_cnt_n = '0;
                            bit_idx_n  = '0;
                            data_n     = '0;
                            par_n      = 1'b0;
                            perr_n     = 1'b0;
                            par_rx_n   = 1'b0;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 8'd1;
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    tick_cnt_n = '0;
                    for (int unsigned i = 0; i < DBIT; i++)
                        if (4'(i) == bit_idx)
                            data_n[i] = rx_sync;
                    par_n = par_q ^ rx_sync;
                    if (bit_idx == dbit_l - 4'd1)
                        state_n = par_en ? ST_PARITY : ST_STOP;
                    else
                        bit_idx_n = bit_idx + 4'd1;
                end else if (s_tick) begin
                    tick_cnt_n = tick_cnt + 8'd1;
                end
            end
            ST_PARITY: begin
                if (sample) begin
                    tick_cnt_n = '0;
                    perr_n     = (par_q ^ rx_sync) != (pbit_l == PAR_ODD);
                    par_rx_n   = rx_sync;
                    state_n    = ST_STOP;
                end else if (s_tick) begin
                    tick_cnt_n = tick_cnt + 8'd1;
                end
            end
            ST_STOP: begin
                if (sample) begin
                    tick_cnt_n = '0;
`ifdef UART_RX_BREAK_EN
                    // par_rx_q is cleared at frame start, so it reads 0 for no-parity frames.
                    if ((data_q == '0) && !par_rx_q && !rx_sync) begin
                        brk_hit = 1'b1;
                        state_n = ST_WAIT_HIGH;
                    end else begin
                        push    = 1'b1;
                        state_n = rx_sync ? ST_IDLE : ST_WAIT_HIGH;
                    end
`else
                    push    = 1'b1;
                    state_n = rx_sync ? ST_IDLE : ST_WAIT_HIGH;
`endif
                end else if (s_tick) begin
                    tick_cnt_n = tick_cnt + 8'd1;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_sync)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign fifo_wdata = {~rx_sync, perr_q, data_q};
    assign pop        = m_valid & m_ready;

    sync_fifo #(
        .WIDTH(DBIT + 2),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .wdata  (fifo_wdata),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign m_valid = ~fifo_empty;
    assign m_data  = m_valid ? fifo_rdata[DBIT-1:0] : '0;
    assign m_perr  = m_valid & fifo_rdata[DBIT];
    assign m_ferr  = m_valid & fifo_rdata[DBIT+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DBIT=8, DEPTH=4, os_tick=16).
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DBIT     = 8;
    localparam int DEPTH    = 4;
    localparam int AW       = $clog2(DEPTH);
    localparam int TICK_DIV = 4;
    localparam int BIT_CLK  = 16 * TICK_DIV;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            s_tick = 1'b0;
    logic [7:0]      os_tick = 8'd16;
    logic [3:0]      dbit = 4'd8;
    logic [1:0]      pbit = 2'd0;
    logic            rx = 1'b1;
    logic            m_ready = 1'b0;
    logic            m_valid, m_perr, m_ferr, overrun;
    logic [DBIT-1:0] m_data;
    logic [AW:0]     fifo_count;
`ifdef UART_RX_BREAK_EN
    logic            brk;
    int              brk_cnt = 0;
`endif

    int errors = 0;
    int checks = 0;
    int ovr_cnt = 0;
    logic [DBIT-1:0] acc_q[$];

    uart_rx_fifo #(
        .DBIT(DBIT),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_tick    (s_tick),
        .os_tick   (os_tick),
        .dbit      (dbit),
        .pbit      (pbit),
        .rx        (rx),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_perr    (m_perr),
        .m_ferr    (m_ferr),
        .overrun   (overrun),
`ifdef UART_RX_BREAK_EN
        .brk       (brk),
`endif
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            s_tick = (div == TICK_DIV - 1);
            div = (div + 1) % TICK_DIV;
        end
    end

    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
`ifdef UART_RX_BREAK_EN
        if (brk) brk_cnt++;
`endif
        if (m_valid && m_ready) acc_q.push_back(m_data);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_frame(input logic [8:0] data, input int nbits,
                              input logic par_en, input logic par_bit,
                              input logic stop_bit);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = data[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        if (par_en) begin
            rx = par_bit;
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic pop_head();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h want 00", m_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
        checks++; if ({m_perr, m_ferr} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {m_perr, m_ferr}); end
    endtask

    task automatic test_8n1();
        dbit = 4'd8; pbit = 2'd0;
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL 8n1_valid: got %b want 1", m_valid); end
        checks++; if (m_data !== 8'hA5) begin errors++; $display("FAIL 8n1_data: got %h want a5", m_data); end
        checks++; if ({m_perr, m_ferr} !== 2'b00) begin errors++; $display("FAIL 8n1_flags: got %b want 00", {m_perr, m_ferr}); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL 8n1_count: got %0d want 1", fifo_count); end
        pop_head();
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL 8n1_pop_count: got %0d want 0", fifo_count); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL 8n1_pop_data: got %h want 00", m_data); end
    endtask

    task automatic test_parity();
        dbit = 4'd7; pbit = 2'd1;
        send_frame(9'h041, 7, 1'b1, 1'b0, 1'b1);
        send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1);
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL 7e1_count: got %0d want 2", fifo_count); end
        checks++; if ({m_data, m_perr, m_ferr} !== {8'h41, 2'b00}) begin errors++; $display("FAIL 7e1_good: got %h/%b%b want 41/00", m_data, m_perr, m_ferr); end
        pop_head();
        checks++; if ({m_data, m_perr, m_ferr} !== {8'h41, 2'b10}) begin errors++; $display("FAIL 7e1_bad: got %h/%b%b want 41/10", m_data, m_perr, m_ferr); end
        pop_head();
        dbit = 4'd5; pbit = 2'd2;
        send_frame(9'h013, 5, 1'b1, 1'b0, 1'b1);
        checks++; if ({fifo_count, m_data, m_perr} !== {3'd1, 8'h13, 1'b0}) begin errors++; $display("FAIL 5o1: got cnt=%0d %h perr=%b want cnt=1 13 perr=0", fifo_count, m_data, m_perr); end
        pop_head();
        dbit = 4'd2; pbit = 2'd3;
        send_frame(9'h01B, 5, 1'b0, 1'b0, 1'b1);
        checks++; if ({fifo_count, m_data, m_perr, m_ferr} !== {3'd1, 8'h1B, 2'b00}) begin errors++; $display("FAIL clamp5_pbit3: got cnt=%0d %h %b%b want cnt=1 1b 00", fifo_count, m_data, m_perr, m_ferr); end
        pop_head();
        dbit = 4'd8; pbit = 2'd0;
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLK * 12) @(negedge clk);
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL glitch_count: got %0d want 0", fifo_count); end
        checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL glitch_state: got %0d want IDLE", dut.state); end
    endtask

    task automatic test_overrun();
        logic [7:0] vals [5];
        int ovr_start;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        ovr_start = ovr_cnt;
        for (int k = 0; k < DEPTH + 1; k++)
            send_frame({1'b0, vals[k]}, 8, 1'b0, 1'b0, 1'b1);
        checks++; if (fifo_count !== 3'(DEPTH)) begin errors++; $display("FAIL ovr_count: got %0d want %0d", fifo_count, DEPTH); end
        checks++; if (ovr_cnt - ovr_start !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt - ovr_start); end
        for (int k = 0; k < DEPTH; k++) begin
            checks++; if (m_data !== vals[k]) begin errors++; $display("FAIL ovr_order%0d: got %h want %h", k, m_data, vals[k]); end
            pop_head();
        end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL ovr_drain: got %0d want 0", fifo_count); end
    endtask

    task automatic test_back_to_back();
        int ovr_start;
        ovr_start = ovr_cnt;
        acc_q.delete();
        m_ready = 1'b1;
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1);
        send_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b1);
        send_frame(9'h00F, 8, 1'b0, 1'b0, 1'b1);
        m_ready = 1'b0;
        @(negedge clk);
        checks++; if (acc_q.size() !== 3) begin errors++; $display("FAIL b2b_size: got %0d want 3", acc_q.size()); end
        else begin
            checks++; if ({acc_q[0], acc_q[1], acc_q[2]} !== 24'h5AC30F) begin errors++; $display("FAIL b2b_data: got %h%h%h want 5ac30f", acc_q[0], acc_q[1], acc_q[2]); end
        end
        checks++; if ({fifo_count, 32'(ovr_cnt - ovr_start)} !== {3'd0, 32'd0}) begin errors++; $display("FAIL b2b_end: got cnt=%0d ovr=%0d want 0/0", fifo_count, ovr_cnt - ovr_start); end
    endtask

    task automatic test_ferr();
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0);
        repeat (BIT_CLK * 2) @(negedge clk);
        checks++; if ({fifo_count, m_data, m_perr, m_ferr} !== {3'd1, 8'h3C, 2'b01}) begin errors++; $display("FAIL ferr_frame: got cnt=%0d %h %b%b want cnt=1 3c 01", fifo_count, m_data, m_perr, m_ferr); end
        checks++; if (dut.state !== ST_WAIT_HIGH) begin errors++; $display("FAIL ferr_wait: got %0d want WAIT_HIGH", dut.state); end
        rx = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        checks++; if ({dut.state == ST_IDLE, fifo_count} !== {1'b1, 3'd1}) begin errors++; $display("FAIL ferr_release: got state=%0d cnt=%0d want IDLE cnt=1", dut.state, fifo_count); end
        pop_head();
    endtask

    task automatic test_break();
`ifdef UART_RX_BREAK_EN
        int brk_start;
        brk_start = brk_cnt;
`endif
        rx = 1'b0;
        repeat (BIT_CLK * 20) @(negedge clk);
        checks++; if (dut.state !== ST_WAIT_HIGH) begin errors++; $display("FAIL break_wait: got %0d want WAIT_HIGH", dut.state); end
        rx = 1'b1;
        repeat (BIT_CLK * 2) @(negedge clk);
`ifdef UART_RX_BREAK_EN
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL break_count: got %0d want 0", fifo_count); end
        checks++; if (brk_cnt - brk_start !== 1) begin errors++; $display("FAIL break_pulse: got %0d want 1", brk_cnt - brk_start); end
`else
        checks++; if ({fifo_count, m_data, m_perr, m_ferr} !== {3'd1, 8'h00, 2'b01}) begin errors++; $display("FAIL break_frame: got cnt=%0d %h %b%b want cnt=1 00 01", fifo_count, m_data, m_perr, m_ferr); end
        pop_head();
`endif
    endtask

    task automatic test_reset_midframe();
        rx = 1'b0;
        repeat (BIT_CLK * 3) @(negedge clk);
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (BIT_CLK * 12) @(negedge clk);
        checks++; if ({fifo_count, m_valid} !== {3'd0, 1'b0}) begin errors++; $display("FAIL midreset_count: got cnt=%0d valid=%b want 0/0", fifo_count, m_valid); end
        checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL midreset_state: got %0d want IDLE", dut.state); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_overrun();
        test_back_to_back();
        test_ferr();
        test_break();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
